// File: rtl/muldiv_unit_if.sv
// Operand/result bundle between the ID/EX stage and the muldiv engine.
// Pure wiring, no latency of its own.
// The engine pushes back on the pipeline through stall; it never waits on the pipeline.
interface muldiv_unit_if;
  logic        op_valid;
  logic [5:0]  funct_in;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] hilo_out;

  // Pipeline side: presents the EX-stage instruction and consumes the results.
  modport master (
    output op_valid, funct_in, src_a, src_b,
    input  stall, busy, done, hi, lo, hilo_out
  );

  // Engine side.
  modport slave (
    input  op_valid, funct_in, src_a, src_b,
    output stall, busy, done, hi, lo, hilo_out
  );
endinterface

// File: rtl/muldiv_unit.sv
// Unsigned MULTU/DIVU engine owning HI/LO.
// Latency: 32 iterations + 1 DONE cycle (DIVU by zero completes in 1 cycle).
// Backpressure: stall freezes PC, IF/ID and ID/EX from detect until DONE.
module muldiv_unit #(
  parameter logic [5:0] F_MULTU = 6'h19,
  parameter logic [5:0] F_DIVU  = 6'h1B,
  parameter logic [5:0] F_MFHI  = 6'h10,
  parameter logic [5:0] F_MFLO  = 6'h12
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q;
  logic [63:0] acc_q;     // multiply: {partial product, remaining multiplier bits}
  logic [31:0] mcand_q;   // multiplicand held for the whole multiply
  logic [31:0] rem_q;     // divide: running remainder (always < divisor, so 32 bits hold it)
  logic [31:0] quo_q;     // divide: dividend bits shifting out, quotient bits shifting in
  logic [31:0] dvs_q;     // divisor held for the whole divide
  logic [4:0]  cnt_q;     // iteration index, 0..31
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic        is_multu;
  logic        is_divu;
  logic        last_iter;
  logic [32:0] mul_upper;
  logic [63:0] acc_d;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] rem_d;
  logic [31:0] quo_d;

  assign is_multu  = (bus.funct_in == F_MULTU);
  assign is_divu   = (bus.funct_in == F_DIVU);
  assign last_iter = (cnt_q == 5'd31);

  // One shift-add multiply step and one restoring divide step, evaluated every cycle.
  always_comb begin
    mul_upper = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? mcand_q : 32'd0)};
    // The 65-bit {carry, upper, low} shifted right by one drops acc_q[0].
    acc_d     = {mul_upper, acc_q[31:1]};
    // Shifted remainder needs 33 bits: the bit shifted out of rem_q[31] matters for the compare.
    div_shift = {rem_q, quo_q[31]};
    div_ge    = (div_shift >= {1'b0, dvs_q});
    // When div_ge is set the true difference is below the divisor, so 32 bits are exact.
    rem_d     = div_ge ? (div_shift[31:0] - dvs_q) : div_shift[31:0];
    quo_d     = {quo_q[30:0], div_ge};
  end

  // Control FSM plus datapath registers; HI/LO are written only on entry to DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= 64'd0;
      mcand_q <= 32'd0;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      dvs_q   <= 32'd0;
      cnt_q   <= 5'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.op_valid && is_multu) begin
            mcand_q <= bus.src_a;
            acc_q   <= {32'd0, bus.src_b};
            cnt_q   <= 5'd0;
            state_q <= S_MUL;
          end else if (bus.op_valid && is_divu && (bus.src_b != 32'd0)) begin
            rem_q   <= 32'd0;
            quo_q   <= bus.src_a;
            dvs_q   <= bus.src_b;
            cnt_q   <= 5'd0;
            state_q <= S_DIV;
          end else if (bus.op_valid && is_divu) begin
            // Defined divide-by-zero result: HI = dividend, LO = all ones.
            hi_q    <= bus.src_a;
            lo_q    <= 32'hFFFF_FFFF;
            state_q <= S_DONE;
          end
        end
        S_MUL: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 5'd1;
          if (last_iter) begin
            hi_q    <= acc_d[63:32];
            lo_q    <= acc_d[31:0];
            state_q <= S_DONE;
          end
        end
        S_DIV: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 5'd1;
          if (last_iter) begin
            hi_q    <= rem_d;
            lo_q    <= quo_d;
            state_q <= S_DONE;
          end
        end
        // DONE ignores op_valid so the instruction still sitting in EX is not re-issued.
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Status decoded straight from the state register; the IDLE term lets the
  // detect cycle itself hold the pipeline.
  assign bus.busy  = (state_q == S_MUL) || (state_q == S_DIV);
  assign bus.done  = (state_q == S_DONE);
  assign bus.stall = bus.busy ||
                     ((state_q == S_IDLE) && bus.op_valid && (is_multu || is_divu));
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.hilo_out = (bus.funct_in == F_MFHI) ? hi_q :
                        (bus.funct_in == F_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, results, divide-by-zero, async reset, re-trigger.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Each scenario task does its own comparisons and updates checks/errors.
module tb_muldiv_unit;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  muldiv_unit_if mdif ();

  muldiv_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (mdif)
  );

  always #5 clk = ~clk;

  // Drive the EX-stage instruction fields.
  task automatic drive(input logic v, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    mdif.op_valid = v;
    mdif.funct_in = f;
    mdif.src_a    = a;
    mdif.src_b    = b;
  endtask

  // Issue an op after the next rising edge and hold it until the done pulse (or budget);
  // cycle 1 is the first falling edge after issue. Inputs are left held on return.
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int stalls, output int done_cyc);
    int cyc;
    cyc      = 0;
    stalls   = 0;
    done_cyc = -1;
    @(posedge clk); #1;
    drive(1'b1, f, a, b);
    while (done_cyc < 0 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (mdif.stall === 1'b1) stalls++;
      if (mdif.done === 1'b1) done_cyc = cyc;
    end
  endtask

  // Present MFHI/MFLO for one cycle and return what the EX mux would see.
  task automatic read_hilo(input logic [5:0] f, output logic [31:0] val, output logic st, output logic dn);
    @(posedge clk); #1;
    drive(1'b1, f, 32'd0, 32'd0);
    @(negedge clk);
    val = mdif.hilo_out;
    st  = mdif.stall;
    dn  = mdif.done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 6'd0, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    checks++; if (mdif.stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", mdif.stall); end
    checks++; if (mdif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", mdif.busy); end
    checks++; if (mdif.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", mdif.done); end
    checks++; if (mdif.hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %h want 0", mdif.hi); end
    checks++; if (mdif.lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h want 0", mdif.lo); end
    rst = 1'b0;
  endtask

  task automatic test_multu_small();
    int s, d;
    logic [31:0] v;
    logic st, dn;
    run_op(F_MULTU, 32'd7, 32'd6, s, d);
    checks++; if (s != 33) begin errors++; $display("FAIL mul7x6_stall_cycles got %0d want 33", s); end
    checks++; if (d != 34) begin errors++; $display("FAIL mul7x6_done_cycle got %0d want 34", d); end
    checks++; if (mdif.hi !== 32'd0) begin errors++; $display("FAIL mul7x6_hi got %h want 0", mdif.hi); end
    checks++; if (mdif.lo !== 32'd42) begin errors++; $display("FAIL mul7x6_lo got %0d want 42", mdif.lo); end
    read_hilo(F_MFLO, v, st, dn);
    checks++; if (v !== 32'd42) begin errors++; $display("FAIL mul7x6_mflo got %0d want 42", v); end
    checks++; if (st !== 1'b0) begin errors++; $display("FAIL mul7x6_mflo_stall got %b want 0", st); end
  endtask

  task automatic test_multu_max();
    int s, d;
    logic [31:0] v;
    logic st, dn;
    run_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, s, d);
    checks++; if (s != 33) begin errors++; $display("FAIL mulmax_stall_cycles got %0d want 33", s); end
    checks++; if (mdif.hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mulmax_hi got %h want fffffffe", mdif.hi); end
    checks++; if (mdif.lo !== 32'h0000_0001) begin errors++; $display("FAIL mulmax_lo got %h want 00000001", mdif.lo); end
    read_hilo(F_MFHI, v, st, dn);
    checks++; if (v !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mulmax_mfhi got %h want fffffffe", v); end
  endtask

  task automatic test_divu();
    int s, d;
    run_op(F_DIVU, 32'd100, 32'd7, s, d);
    checks++; if (s != 33) begin errors++; $display("FAIL div100_7_stall_cycles got %0d want 33", s); end
    checks++; if (d != 34) begin errors++; $display("FAIL div100_7_done_cycle got %0d want 34", d); end
    checks++; if (mdif.lo !== 32'd14) begin errors++; $display("FAIL div100_7_lo got %0d want 14", mdif.lo); end
    checks++; if (mdif.hi !== 32'd2) begin errors++; $display("FAIL div100_7_hi got %0d want 2", mdif.hi); end
    run_op(F_DIVU, 32'hFFFF_FFFF, 32'd1, s, d);
    checks++; if (mdif.lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divmax_1_lo got %h want ffffffff", mdif.lo); end
    checks++; if (mdif.hi !== 32'd0) begin errors++; $display("FAIL divmax_1_hi got %h want 0", mdif.hi); end
    run_op(F_DIVU, 32'h8000_0000, 32'd3, s, d);
    checks++; if (mdif.lo !== 32'h2AAA_AAAA) begin errors++; $display("FAIL div8000_3_lo got %h want 2aaaaaaa", mdif.lo); end
    checks++; if (mdif.hi !== 32'd2) begin errors++; $display("FAIL div8000_3_hi got %h want 2", mdif.hi); end
  endtask

  task automatic test_div_zero();
    int s, d;
    run_op(F_DIVU, 32'h1234, 32'd0, s, d);
    checks++; if (s != 1) begin errors++; $display("FAIL divzero_stall_cycles got %0d want 1", s); end
    checks++; if (d != 2) begin errors++; $display("FAIL divzero_done_cycle got %0d want 2", d); end
    checks++; if (mdif.hi !== 32'h1234) begin errors++; $display("FAIL divzero_hi got %h want 1234", mdif.hi); end
    checks++; if (mdif.lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divzero_lo got %h want ffffffff", mdif.lo); end
  endtask

  task automatic test_reset_mid_op();
    int s, d;
    // HI/LO hold the divide-by-zero result here, so a cleared value is visible.
    @(posedge clk); #1;
    drive(1'b1, F_MULTU, 32'd7, 32'd6);
    // Cycle 1 is the detect cycle; cycle 12 is MUL iteration 10.
    repeat (12) @(negedge clk);
    checks++; if (mdif.busy !== 1'b1) begin errors++; $display("FAIL midop_busy_before got %b want 1", mdif.busy); end
    #2;
    rst = 1'b1;
    drive(1'b0, 6'd0, 32'd0, 32'd0);
    #1;
    checks++; if (mdif.stall !== 1'b0) begin errors++; $display("FAIL midop_stall got %b want 0", mdif.stall); end
    checks++; if (mdif.busy !== 1'b0) begin errors++; $display("FAIL midop_busy got %b want 0", mdif.busy); end
    checks++; if (mdif.hi !== 32'd0) begin errors++; $display("FAIL midop_hi got %h want 0", mdif.hi); end
    checks++; if (mdif.lo !== 32'd0) begin errors++; $display("FAIL midop_lo got %h want 0", mdif.lo); end
    @(negedge clk);
    rst = 1'b0;
    run_op(F_MULTU, 32'd3, 32'd5, s, d);
    checks++; if (d != 34) begin errors++; $display("FAIL after_rst_done_cycle got %0d want 34", d); end
    checks++; if (mdif.lo !== 32'd15) begin errors++; $display("FAIL after_rst_lo got %0d want 15", mdif.lo); end
    checks++; if (mdif.hi !== 32'd0) begin errors++; $display("FAIL after_rst_hi got %0d want 0", mdif.hi); end
  endtask

  task automatic test_held_done();
    int s, d;
    logic [31:0] v;
    logic st, dn;
    // run_op keeps op_valid/MULTU asserted through the DONE cycle.
    run_op(F_MULTU, 32'd9, 32'd9, s, d);
    checks++; if (d != 34) begin errors++; $display("FAIL held_done_cycle got %0d want 34", d); end
    read_hilo(F_MFHI, v, st, dn);
    checks++; if (st !== 1'b0) begin errors++; $display("FAIL held_mfhi_stall got %b want 0", st); end
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL held_mfhi got %h want 0", v); end
    checks++; if (dn !== 1'b0) begin errors++; $display("FAIL held_second_done got %b want 0", dn); end
    read_hilo(F_MFLO, v, st, dn);
    checks++; if (v !== 32'd81) begin errors++; $display("FAIL held_mflo got %0d want 81", v); end
    checks++; if (mdif.busy !== 1'b0) begin errors++; $display("FAIL held_retrigger_busy got %b want 0", mdif.busy); end
  endtask

  task automatic test_back_to_back();
    int s, d;
    run_op(F_MULTU, 32'd7, 32'd6, s, d);
    // Second MULTU arrives in the IDLE cycle right after DONE.
    run_op(F_MULTU, 32'h0001_0000, 32'h0001_0000, s, d);
    checks++; if (s != 33) begin errors++; $display("FAIL b2b_stall_cycles got %0d want 33", s); end
    checks++; if (d != 34) begin errors++; $display("FAIL b2b_done_cycle got %0d want 34", d); end
    checks++; if (mdif.hi !== 32'd1) begin errors++; $display("FAIL b2b_hi got %h want 1", mdif.hi); end
    checks++; if (mdif.lo !== 32'd0) begin errors++; $display("FAIL b2b_lo got %h want 0", mdif.lo); end
    @(posedge clk); #1;
    drive(1'b0, 6'd0, 32'd0, 32'd0);
  endtask

  initial begin
    test_reset();
    test_multu_small();
    test_multu_max();
    test_divu();
    test_div_zero();
    test_reset_mid_op();
    test_held_done();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle unsigned multiply/divide engine in the EX stage of the pipelined MIPS-lite CPU.
- Consumes the decoded operands and funct field that the ID/EX pipeline register presents.
- Owns the HI/LO registers.
- Drives the stall that deasserts en_reg on PC, IF/ID and ID/EX, freezing the pipeline while an operation iterates.

Parameters:
- F_MULTU, 6'h19: funct code for unsigned multiply.
- F_DIVU, 6'h1B: funct code for unsigned divide.
- F_MFHI, 6'h10: funct code for move-from-HI.
- F_MFLO, 6'h12: funct code for move-from-LO.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  reset; asynchronous, active-high.
- op_valid  in  1  the EX-stage instruction is an R-type muldiv-class op (from the EXE control bits).
- funct_in  in  6  funct field of the EX-stage instruction.
- src_a  in  32  rs operand after forwarding (multiplicand / dividend).
- src_b  in  32  rt operand after forwarding (multiplier / divisor).
- stall  out  1  high = hold PC, IF/ID, ID/EX (drives en_reg low).
- busy  out  1  high while in the MUL or DIV state.
- done  out  1  one-cycle pulse when HI/LO have just been updated.
- hi  out  32  HI register.
- lo  out  32  LO register.
- hilo_out  out  32  MFHI ? hi : MFLO ? lo : 0 (combinational, for the EX result mux).

Behaviour:
- Reset (async, any state): state=IDLE; hi=lo=0; counter, accumulator and divisor registers=0. Outputs: stall=0, busy=0, done=0.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - op_valid && funct_in==F_MULTU: latch src_a, src_b; acc={32'b0,src_b}; cnt=0; next state MUL.
  - op_valid && funct_in==F_DIVU && src_b!=0: rem=0 (33b); quo=src_a; dvs=src_b; cnt=0; next state DIV.
  - op_valid && funct_in==F_DIVU && src_b==0: hi<=src_a; lo<=32'hFFFFFFFF; next state DONE. This is the defined divide-by-zero result.
  - Any other funct: stay IDLE.
- MUL, one iteration per cycle:
  - upper = acc[63:32] + (acc[0] ? mcand : 0), computed at 33 bits.
  - acc <= {carry, upper, acc[31:1]}, i.e. a 65-bit result shifted right by 1.
  - cnt++.
  - On the iteration where cnt==31: hi/lo <= final acc in the same edge; next state DONE.
- DIV, restoring, one iteration per cycle:
  - Shift {rem,quo} left 1.
  - If shifted rem >= dvs: rem -= dvs and set quo[0]=1.
  - cnt++.
  - On cnt==31: hi<=final rem[31:0]; lo<=final quo; next state DONE.
- DONE: done=1 for exactly this cycle; next state IDLE unconditionally. Because DONE ignores op_valid, the held instruction is not re-triggered.
- stall = (state==MUL) | (state==DIV) | (state==IDLE & op_valid & (funct_in==F_MULTU | funct_in==F_DIVU)).
  - stall is low in DONE, so ID/EX advances on the DONE edge.
- busy = state is MUL or DIV.
- Latency:
  - MULTU/DIVU (nonzero divisor): stall high for 33 consecutive cycles (1 IDLE-detect + 32 iterations); instruction occupies EX for 34 cycles.
  - DIVU by zero: stall high 1 cycle, done on the next cycle.
- hi/lo change only on entry to DONE or on reset. MFHI/MFLO issued directly after DONE read the new values.
- MFHI/MFLO never stall: they cannot reach EX while busy, because the pipeline is frozen.
- Back-to-back MULTU: the second starts in the IDLE cycle after DONE. No bubble is needed beyond DONE.
- Arithmetic is unsigned only; a full 64-bit product is kept and there is no overflow flag.
- Reset mid-operation: stall drops asynchronously and the partial result is discarded.

Test Plan:
- MULTU src_a=7, src_b=6 -> stall high exactly 33 cycles; done pulse in cycle 34; hi=0, lo=42; hilo_out with MFLO=42.
- MULTU src_a=src_b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001 after 33 stall cycles.
- DIVU src_a=100, src_b=7 -> lo=14, hi=2; then DIVU 32'hFFFFFFFF/1 -> lo=32'hFFFFFFFF, hi=0.
- DIVU src_a=32'h1234, src_b=0 -> stall 1 cycle; hi=32'h1234, lo=32'hFFFFFFFF; done pulse next cycle.
- Assert rst during MUL iteration 10 -> stall, busy, hi, lo all 0 immediately (before the next clk edge); state IDLE; a subsequent MULTU 3*5 gives lo=15.
- MULTU 9*9 held by op_valid through DONE -> exactly one done pulse, no re-trigger; next cycle with op_valid=1, funct=F_MFHI -> stall=0, hilo_out=0; with F_MFLO -> 81.
